// File: rtl/wave_player_pkg.sv
// Shared types and helpers for the waveform ROM player.
// Optional macro WAVE_QUARTER_EN selects a quarter-period ROM; it changes the
// ROM address width returned by rom_aw().
package wave_player_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // ROM address width for a given logical phase width.
   function automatic int unsigned rom_aw(input int unsigned addr_w);
`ifdef WAVE_QUARTER_EN
      return addr_w - 2;
`else
      return addr_w;
`endif
   endfunction

endpackage

// File: rtl/wave_rom_player_tick_gen.sv
// Sample-strobe divider for the waveform player.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr_i      : synchronous clear of the counter (wins over enable)
//   en_i       : count enable
//   tick_c     : combinational 1-cycle strobe when the counter is at DIV-1
module tick_gen #(
   parameter int unsigned DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_c
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_end;

   assign at_end = (cnt_q == CNT_W'(DIV - 1));
   assign tick_c = en_i & at_end;

   // Count 0..DIV-1 and wrap while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wave_rom_player.sv
// Waveform sequencer: ticks a phase accumulator, reads a 1-cycle-latency
// synchronous ROM once per tick and presents one sample per read.
// Optional macro WAVE_QUARTER_EN: ROM holds a quarter period; the full period
// is rebuilt by mirroring the address and negating the second half.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, stop     : 1-cycle control pulses (stop wins over start in IDLE)
//   mode_loop, step : playback mode and phase increment, sampled at start
//   rom_en/rom_addr : ROM read request, one pulse per tick
//   rom_data        : ROM read data, valid the cycle after rom_en
//   sample          : held sample; shows the new value while sample_valid
//   sample_valid    : 1-cycle strobe, one cycle after rom_en
//   busy, done      : activity flag and end-of-playback pulse
module wave_rom_player
   import wave_player_pkg::*;
#(
   parameter  int unsigned DATA_W   = 32,
   parameter  int unsigned ADDR_W   = 6,
   parameter  int unsigned TICK_DIV = 1000,
   localparam int unsigned ROM_AW   = rom_aw(ADDR_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              mode_loop,
   input  logic [ADDR_W-1:0] step,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] phase_q, phase_d;
   logic [ADDR_W-1:0] step_q, step_d;
   logic              loop_q, loop_d;
   logic              rom_en_q, rom_en_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic              sample_valid_q, sample_valid_d;
   logic [DATA_W-1:0] sample_q, sample_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              tick;
   logic              cnt_clr;
   logic [ADDR_W:0]   phase_sum;
   logic [ROM_AW-1:0] addr_map;
   logic [DATA_W-1:0] sample_new;

   tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr),
      .en_i   (state_q == RUN),
      .tick_c (tick)
   );

   // Extra top bit is the one-shot end-of-period carry.
   assign phase_sum = {1'b0, phase_q} + {1'b0, step_q};

`ifdef WAVE_QUARTER_EN
   // Quadrant bit ADDR_W-2 mirrors the table; ADDR_W-1 selects negation,
   // carried alongside the read so it lines up with rom_data.
   logic [ROM_AW-1:0] quarter_idx;
   logic              neg_a_q, neg_a_d;
   logic              neg_d_q, neg_d_d;

   assign quarter_idx = phase_q[ROM_AW-1:0];
   assign addr_map    = phase_q[ADDR_W-2] ? ~quarter_idx : quarter_idx;
   assign sample_new  = neg_d_q ? -rom_data : rom_data;

   always_comb begin
      neg_a_d = neg_a_q;
      neg_d_d = neg_a_q;
      if (rom_en_d) begin
         neg_a_d = phase_q[ADDR_W-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_a_q <= 1'b0;
         neg_d_q <= 1'b0;
      end else begin
         neg_a_q <= neg_a_d;
         neg_d_q <= neg_d_d;
      end
   end
`else
   assign addr_map   = phase_q;
   assign sample_new = rom_data;
`endif

   // Next-state and output logic.
   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      step_d         = step_q;
      loop_d         = loop_q;
      rom_en_d       = 1'b0;
      rom_addr_d     = rom_addr_q;
      sample_valid_d = rom_en_q;
      sample_d       = sample_valid_q ? sample_new : sample_q;
      done_d         = 1'b0;
      cnt_clr        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = RUN;
               phase_d = '0;
               step_d  = (step == '0) ? ADDR_W'(1) : step;
               loop_d  = mode_loop;
               cnt_clr = 1'b1;
            end
         end
         RUN: begin
            if (tick) begin
               // The tick read is issued even when stop arrives with it.
               rom_en_d   = 1'b1;
               rom_addr_d = addr_map;
               phase_d    = phase_sum[ADDR_W-1:0];
               if (stop || (!loop_q && phase_sum[ADDR_W])) begin
                  state_d = FLUSH;
               end
            end else if (stop) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            // Wait until no read is pending in the ROM.
            if (!rom_en_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         phase_q        <= '0;
         step_q         <= '0;
         loop_q         <= 1'b0;
         rom_en_q       <= 1'b0;
         rom_addr_q     <= '0;
         sample_valid_q <= 1'b0;
         sample_q       <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         step_q         <= step_d;
         loop_q         <= loop_d;
         rom_en_q       <= rom_en_d;
         rom_addr_q     <= rom_addr_d;
         sample_valid_q <= sample_valid_d;
         sample_q       <= sample_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign rom_en       = rom_en_q;
   assign rom_addr     = rom_addr_q;
   assign sample_valid = sample_valid_q;
   // ROM data arrives in the valid cycle, so it is bypassed straight out then.
   assign sample       = sample_valid_q ? sample_new : sample_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_wave_rom_player.sv
// Scoreboard bench for wave_rom_player: randomized playback runs against a
// phase-arithmetic reference model and a behavioural synchronous ROM.
module tb_wave_rom_player;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 6;
   localparam int unsigned TICK_DIV = 10;
`ifdef WAVE_QUARTER_EN
   localparam int unsigned ROM_AW   = ADDR_W - 2;
`else
   localparam int unsigned ROM_AW   = ADDR_W;
`endif
   localparam int NPTS = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              mode_loop = 1'b0;
   logic [ADDR_W-1:0] step = '0;
   logic              rom_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data = '0;
   logic [DATA_W-1:0] sample;
   logic              sample_valid;
   logic              busy;
   logic              done;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;

   int              exp_addr_q[$];
   logic [DATA_W-1:0] exp_smp_q[$];

   // Monitor-owned state.
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  last_sv_cyc = -100;
   int  last_en_cyc = -1;
   bit  prev_en = 1'b0;
   int  busy_low_cnt = 0;
   // Driver-owned state read by the monitor.
   bit  run_active = 1'b0;
   int  run_d0 = 0;

   wave_rom_player #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stop         (stop),
      .mode_loop    (mode_loop),
      .step         (step),
      .rom_en       (rom_en),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .sample       (sample),
      .sample_valid (sample_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] rom_word(input int a);
`ifdef WAVE_QUARTER_EN
      return DATA_W'(a + 1);
`else
      return DATA_W'(a);
`endif
   endfunction

   // Behavioural synchronous ROM, 1-cycle read latency.
   always @(posedge clk) if (rom_en) rom_data <= rom_word(int'(rom_addr));

   // Reference model: ROM address for logical phase k.
   function automatic int ref_addr(input int k);
`ifdef WAVE_QUARTER_EN
      int q;
      int i;
      q = k / (NPTS / 4);
      i = k % (NPTS / 4);
      return (q % 2 == 1) ? (NPTS / 4 - 1 - i) : i;
`else
      return k;
`endif
   endfunction

   // Reference model: sample value for logical phase k.
   function automatic logic [DATA_W-1:0] ref_sample(input int k);
`ifdef WAVE_QUARTER_EN
      int v;
      v = ref_addr(k) + 1;
      return (k >= NPTS / 2) ? DATA_W'(-v) : DATA_W'(v);
`else
      return DATA_W'(k);
`endif
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_en_cyc = -1;
         prev_en     = 1'b0;
      end else begin
         if (rom_en) begin
            if (exp_addr_q.size() == 0) check("unexpected_rom_en", 1, 0);
            else check("rom_addr", longint'(rom_addr), longint'(exp_addr_q.pop_front()));
            if (last_en_cyc >= 0) check("tick_interval", cyc - last_en_cyc, TICK_DIV);
            last_en_cyc = cyc;
         end
         if (sample_valid) begin
            check("valid_after_rom_en", longint'(prev_en), 1);
            if (exp_smp_q.size() == 0) check("unexpected_sample_valid", 1, 0);
            else check("sample", longint'(sample), longint'(exp_smp_q.pop_front()));
            last_sv_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc    = cyc;
            last_en_cyc = -1;
         end
         if (run_active && !busy && !done && done_cnt == run_d0) busy_low_cnt++;
         prev_en = rom_en;
      end
   end

   // One playback run. stop_m < 0: no stop; otherwise stop is sampled
   // stop_m+1 edges after the start edge.
   task automatic run(input bit lp, input int s, input int stop_m);
      int se, nshot, n, ns, bl0, k;
      logic [DATA_W-1:0] last_smp;
      bit gap_ok;
      se    = (s == 0) ? 1 : s;
      nshot = (NPTS + se - 1) / se;
      n     = lp ? 1000000 : nshot;
      if (stop_m >= 0) begin
         ns = (stop_m + 1 >= TICK_DIV) ? (stop_m + 1 - TICK_DIV) / TICK_DIV + 1 : 0;
         if (ns < n) n = ns;
      end
      last_smp = '0;
      for (int j = 0; j < n; j++) begin
         k = (j * se) % NPTS;
         exp_addr_q.push_back(ref_addr(k));
         exp_smp_q.push_back(ref_sample(k));
         last_smp = ref_sample(k);
      end
      gap_ok = (stop_m < 0) || ((stop_m + 1) % TICK_DIV == 0) || (!lp && n == nshot);
      run_d0 = done_cnt;
      bl0    = busy_low_cnt;
      @(negedge clk);
      mode_loop = lp;
      step      = ADDR_W'(s);
      start     = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      run_active = 1'b1;
      mode_loop  = 1'($urandom);
      step       = ADDR_W'($urandom);
      check("busy_after_start", longint'(busy), 1);
      // A start while busy must be ignored.
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (stop_m >= 0) begin
         repeat (stop_m - 4) @(negedge clk);
         stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
      end
      for (int t = 0; t < NPTS * TICK_DIV + 100 && done_cnt == run_d0; t++) @(posedge clk);
      check("done_seen", done_cnt - run_d0, 1);
      @(negedge clk);
      run_active = 1'b0;
      check("busy_low_after_done", longint'(busy), 0);
      check("done_single_pulse", longint'(done), 0);
      check("addr_queue_drained", exp_addr_q.size(), 0);
      check("sample_queue_drained", exp_smp_q.size(), 0);
      check("busy_held_during_run", busy_low_cnt - bl0, 0);
      if (n > 0 && gap_ok) check("done_after_last_valid", done_cyc - last_sv_cyc, 1);
      if (n > 0) check("sample_hold", longint'(sample), longint'(last_smp));
      exp_addr_q.delete();
      exp_smp_q.delete();
      repeat (5) @(negedge clk);
   endtask

   initial begin
      int bad;
      int d0;
      #1;
      check("reset_rom_en", longint'(rom_en), 0);
      check("reset_busy", longint'(busy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle for 100 clocks: everything stays at zero.
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (rom_en || sample_valid || busy || done || sample != '0 || rom_addr != '0) bad++;
      end
      check("idle_outputs_zero", bad, 0);

      // Loop, step 1, stop on the tick of read 65: addresses 0..63,0,1.
      run(1'b1, 1, TICK_DIV - 1 + TICK_DIV * 65);
      // One-shot, step 5: 13 reads.
      run(1'b0, 5, -1);
      // Loop, stop on the tick of address 7.
      run(1'b1, 1, TICK_DIV - 1 + TICK_DIV * 7);
      // Step 0 behaves as step 1.
      run(1'b0, 0, -1);

      // start and stop together in IDLE: stop wins.
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) bad++;
      end
      check("start_stop_idle_busy", bad, 0);
      check("start_stop_idle_done", done_cnt - d0, 0);

      // Asynchronous reset mid-run after two reads.
      for (int j = 0; j < 2; j++) begin
         exp_addr_q.push_back(ref_addr(j));
         exp_smp_q.push_back(ref_sample(j));
      end
      d0 = done_cnt;
      @(negedge clk);
      mode_loop = 1'b1;
      step      = ADDR_W'(1);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_busy", longint'(busy), 0);
      check("rst_rom_en", longint'(rom_en), 0);
      check("rst_sample", longint'(sample), 0);
      check("rst_sample_valid", longint'(sample_valid), 0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy || rom_en) bad++;
      end
      check("rst_no_done", bad, 0);
      rst_n = 1'b1;
      check("rst_reads_before_reset", exp_addr_q.size() + exp_smp_q.size(), 0);
      exp_addr_q.delete();
      exp_smp_q.delete();
      repeat (5) @(negedge clk);
      check("rst_done_count", done_cnt - d0, 0);
      // Restart must begin at address 0.
      run(1'b1, 1, TICK_DIV - 1 + TICK_DIV * 3);

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         bit lp;
         int s, m;
         lp = 1'($urandom);
         s  = int'($urandom_range(0, NPTS - 1));
         if (lp || $urandom_range(0, 1) == 1) m = int'($urandom_range(4, 400));
         else m = -1;
         if ($urandom_range(0, 2) == 0 && m >= 0)
            m = ((m / TICK_DIV) + 1) * TICK_DIV - 1;
         run(lp, s, m);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d", pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule
